// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, drives the hardware return
// stack's push/pop strobes, tracks stack depth and generates the post-branch flush.
module pc_sequencer #(
  parameter int PC_W      = 11,
  parameter int DEPTH     = 16,
  parameter int RESET_VEC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic [PC_W-1:0] target,
  input  logic [8:0]      bra_off,
  input  logic            skip_cond,
  input  logic [PC_W-1:0] ret_addr,
  input  logic            stk_clr,
  output logic [PC_W-1:0] pc,
  output logic            push,
  output logic            pop,
  output logic [PC_W-1:0] stack_in,
  output logic            flush,
  output logic [4:0]      stk_depth,
  output logic            stkovf,
  output logic            stkunf
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_GOTO = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_BRA  = 3'd4,
    OP_SKIP = 3'd5
  } op_t;

  localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);
  localparam logic [4:0]      DEPTH_MAX = 5'(DEPTH);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [4:0]      r_depth;
  logic            r_stkovf;
  logic            r_stkunf;

  state_t          w_state_next;
  logic [PC_W-1:0] w_pc_next;
  logic [4:0]      w_depth_next;
  logic            w_set_ovf;
  logic            w_set_unf;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_bra;

  // Offset is sign-extended to PC width, so the sum wraps modulo 2^PC_W.
  assign w_pc_inc = r_pc + PC_ONE;
  assign w_pc_bra = r_pc + {{(PC_W-9){bra_off[8]}}, bra_off};

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_depth_next = r_depth;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;

    if (!reset && en) begin
      if (r_state == ST_FLUSH) begin
        w_pc_next    = w_pc_inc;
        w_state_next = ST_RUN;
      end else begin
        unique case (op)
          OP_GOTO: begin
            w_pc_next    = target;
            w_state_next = ST_FLUSH;
          end
          OP_CALL: begin
            // A full stack loses the return address but the jump still happens.
            if (r_depth == DEPTH_MAX) begin
              w_set_ovf = 1'b1;
            end else begin
              w_push       = 1'b1;
              w_depth_next = r_depth + 5'd1;
            end
            w_pc_next    = target;
            w_state_next = ST_FLUSH;
          end
          OP_RET: begin
            if (r_depth == 5'd0) begin
              w_set_unf = 1'b1;
              w_pc_next = PC_RESET;
            end else begin
              w_pop        = 1'b1;
              w_depth_next = r_depth - 5'd1;
              w_pc_next    = ret_addr;
            end
            w_state_next = ST_FLUSH;
          end
          OP_BRA: begin
            w_pc_next    = w_pc_bra;
            w_state_next = ST_FLUSH;
          end
          OP_SKIP: begin
            w_pc_next    = w_pc_inc;
            w_state_next = skip_cond ? ST_FLUSH : ST_RUN;
          end
          default: begin
            w_pc_next    = w_pc_inc;
            w_state_next = ST_RUN;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FLUSH;
      r_pc    <= PC_RESET;
      r_depth <= 5'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_depth <= w_depth_next;
    end
  end

  // Flags are cleared by stk_clr even while the pipeline is stalled; a set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stkovf <= 1'b0;
      r_stkunf <= 1'b0;
    end else begin
      if (w_set_ovf)    r_stkovf <= 1'b1;
      else if (stk_clr) r_stkovf <= 1'b0;
      if (w_set_unf)    r_stkunf <= 1'b1;
      else if (stk_clr) r_stkunf <= 1'b0;
    end
  end

  assign pc        = r_pc;
  assign push      = w_push;
  assign pop       = w_pop;
  assign stack_in  = r_pc;
  assign flush     = (r_state == ST_FLUSH);
  assign stk_depth = r_depth;
  assign stkovf    = r_stkovf;
  assign stkunf    = r_stkunf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: reset, CALL/RET, stack
// overflow/underflow, BRA wrap, SKIP and pipeline stall.
module tb_pc_sequencer;

  localparam int PC_W = 11;

  logic            clk;
  logic            reset;
  logic            en;
  logic [2:0]      op;
  logic [PC_W-1:0] target;
  logic [8:0]      bra_off;
  logic            skip_cond;
  logic [PC_W-1:0] ret_addr;
  logic            stk_clr;
  logic [PC_W-1:0] pc;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] stack_in;
  logic            flush;
  logic [4:0]      stk_depth;
  logic            stkovf;
  logic            stkunf;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] SEQ = 3'd0, GOTO = 3'd1, CALL = 3'd2, RET = 3'd3,
                         BRA = 3'd4, SKIP = 3'd5;

  pc_sequencer #(.PC_W(PC_W), .DEPTH(16), .RESET_VEC(0)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .target(target),
    .bra_off(bra_off), .skip_cond(skip_cond), .ret_addr(ret_addr),
    .stk_clr(stk_clr), .pc(pc), .push(push), .pop(pop), .stack_in(stack_in),
    .flush(flush), .stk_depth(stk_depth), .stkovf(stkovf), .stkunf(stkunf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then settle so registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reach RUN state with pc == addr via GOTO addr-1 plus its flush cycle.
  task automatic goto_run(input logic [PC_W-1:0] addr);
    en = 1'b1; op = GOTO; target = addr - 11'd1;
    tick();
    op = SEQ;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; op = CALL; target = 11'h123;
    #1;
    checks++; if (push !== 1'b0) begin $display("FAIL reset_push: got %b expected 0", push); errors++; end
    tick(); tick();
    op = RET;
    #1;
    checks++; if (pop !== 1'b0) begin $display("FAIL reset_pop: got %b expected 0", pop); errors++; end
    checks++; if (pc !== 11'h000) begin $display("FAIL reset_pc: got %h expected 000", pc); errors++; end
    checks++; if (flush !== 1'b1) begin $display("FAIL reset_flush: got %b expected 1", flush); errors++; end
    checks++; if (stk_depth !== 5'd0) begin $display("FAIL reset_depth: got %0d expected 0", stk_depth); errors++; end
    checks++; if ({stkovf, stkunf} !== 2'b00) begin $display("FAIL reset_flags: got %b expected 00", {stkovf, stkunf}); errors++; end
    reset = 1'b0; op = SEQ;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pc !== 11'(i)) begin $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, 11'(i)); errors++; end
      checks++; if (flush !== 1'b0) begin $display("FAIL seq_flush[%0d]: got %b expected 0", i, flush); errors++; end
    end
  endtask

  task automatic test_call_ret();
    goto_run(11'h010);
    op = CALL; target = 11'h200;
    #1;
    checks++; if (push !== 1'b1 || pop !== 1'b0) begin $display("FAIL call_strobe: got push=%b pop=%b expected 1/0", push, pop); errors++; end
    checks++; if (stack_in !== 11'h010) begin $display("FAIL call_stack_in: got %h expected 010", stack_in); errors++; end
    tick();
    checks++; if (pc !== 11'h200 || flush !== 1'b1) begin $display("FAIL call_pc: got pc=%h flush=%b expected 200/1", pc, flush); errors++; end
    checks++; if (stk_depth !== 5'd1) begin $display("FAIL call_depth: got %0d expected 1", stk_depth); errors++; end
    op = SEQ;
    #1;
    checks++; if (push !== 1'b0) begin $display("FAIL flush_push: got %b expected 0", push); errors++; end
    tick();
    checks++; if (pc !== 11'h201 || flush !== 1'b0) begin $display("FAIL call_seq: got pc=%h flush=%b expected 201/0", pc, flush); errors++; end
    op = RET; ret_addr = 11'h010;
    #1;
    checks++; if (pop !== 1'b1 || push !== 1'b0) begin $display("FAIL ret_strobe: got pop=%b push=%b expected 1/0", pop, push); errors++; end
    tick();
    checks++; if (pc !== 11'h010 || flush !== 1'b1) begin $display("FAIL ret_pc: got pc=%h flush=%b expected 010/1", pc, flush); errors++; end
    checks++; if (stk_depth !== 5'd0) begin $display("FAIL ret_depth: got %0d expected 0", stk_depth); errors++; end
    op = SEQ;
    tick();
    checks++; if (pc !== 11'h011) begin $display("FAIL ret_next: got %h expected 011", pc); errors++; end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      op = CALL; target = 11'h100 + 11'(i * 4);
      #1;
      checks++; if (push !== (i < 16)) begin $display("FAIL ovf_push[%0d]: got %b expected %b", i, push, (i < 16)); errors++; end
      tick();
      checks++; if (stk_depth !== ((i < 16) ? 5'(i + 1) : 5'd16)) begin $display("FAIL ovf_depth[%0d]: got %0d", i, stk_depth); errors++; end
      checks++; if (stkovf !== (i == 16)) begin $display("FAIL ovf_flag[%0d]: got %b expected %b", i, stkovf, (i == 16)); errors++; end
      checks++; if (pc !== 11'h100 + 11'(i * 4)) begin $display("FAIL ovf_pc[%0d]: got %h expected %h", i, pc, 11'h100 + 11'(i * 4)); errors++; end
      op = SEQ;
      tick();
    end
    en = 1'b0; stk_clr = 1'b1;
    tick();
    checks++; if (stkovf !== 1'b0) begin $display("FAIL ovf_clear: got %b expected 0", stkovf); errors++; end
    checks++; if (stk_depth !== 5'd16 || pc !== 11'h141) begin $display("FAIL ovf_hold: got depth=%0d pc=%h expected 16/141", stk_depth, pc); errors++; end
    en = 1'b1; op = CALL; target = 11'h300;
    tick();
    checks++; if (stkovf !== 1'b1) begin $display("FAIL ovf_set_wins: got %b expected 1", stkovf); errors++; end
    stk_clr = 1'b0;
  endtask

  task automatic test_underflow();
    reset = 1'b1; tick(); reset = 1'b0; op = SEQ; tick();
    goto_run(11'h050);
    op = RET; ret_addr = 11'h3AA;
    #1;
    checks++; if (pop !== 1'b0) begin $display("FAIL unf_pop: got %b expected 0", pop); errors++; end
    tick();
    checks++; if (pc !== 11'h000 || flush !== 1'b1) begin $display("FAIL unf_pc: got pc=%h flush=%b expected 000/1", pc, flush); errors++; end
    checks++; if (stkunf !== 1'b1 || stk_depth !== 5'd0) begin $display("FAIL unf_flag: got unf=%b depth=%0d expected 1/0", stkunf, stk_depth); errors++; end
    op = SEQ; stk_clr = 1'b1;
    tick();
    stk_clr = 1'b0;
    checks++; if (stkunf !== 1'b0 || pc !== 11'h001) begin $display("FAIL unf_clear: got unf=%b pc=%h expected 0/001", stkunf, pc); errors++; end
  endtask

  task automatic test_bra_wrap();
    goto_run(11'h005);
    op = BRA; bra_off = 9'h1F0;
    tick();
    checks++; if (pc !== 11'h7F5 || flush !== 1'b1) begin $display("FAIL bra_neg: got pc=%h flush=%b expected 7F5/1", pc, flush); errors++; end
    op = SEQ;
    tick();
    checks++; if (pc !== 11'h7F6) begin $display("FAIL bra_next: got %h expected 7F6", pc); errors++; end
    goto_run(11'h7FF);
    tick();
    checks++; if (pc !== 11'h000 || flush !== 1'b0) begin $display("FAIL seq_wrap: got pc=%h flush=%b expected 000/0", pc, flush); errors++; end
    op = BRA; bra_off = 9'h0FF;
    tick();
    checks++; if (pc !== 11'h0FF) begin $display("FAIL bra_pos: got %h expected 0FF", pc); errors++; end
    op = SEQ;
    tick();
  endtask

  task automatic test_skip_stall();
    goto_run(11'h020);
    op = SKIP; skip_cond = 1'b1;
    tick();
    checks++; if (pc !== 11'h021 || flush !== 1'b1) begin $display("FAIL skip_taken: got pc=%h flush=%b expected 021/1", pc, flush); errors++; end
    en = 1'b0; op = CALL; target = 11'h555;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (push !== 1'b0) begin $display("FAIL stall_push[%0d]: got %b expected 0", i, push); errors++; end
      tick();
      checks++; if (pc !== 11'h021 || flush !== 1'b1) begin $display("FAIL stall_hold[%0d]: got pc=%h flush=%b expected 021/1", i, pc, flush); errors++; end
    end
    en = 1'b1; op = SEQ;
    tick();
    checks++; if (pc !== 11'h022 || flush !== 1'b0) begin $display("FAIL skip_after: got pc=%h flush=%b expected 022/0", pc, flush); errors++; end
    op = SKIP; skip_cond = 1'b0;
    tick();
    checks++; if (pc !== 11'h023 || flush !== 1'b0) begin $display("FAIL skip_not: got pc=%h flush=%b expected 023/0", pc, flush); errors++; end
    op = 3'd7;
    tick();
    checks++; if (pc !== 11'h024 || flush !== 1'b0) begin $display("FAIL op7_seq: got pc=%h flush=%b expected 024/0", pc, flush); errors++; end
  endtask

  task automatic test_reset_mid_call();
    op = CALL; target = 11'h2A0;
    tick();
    reset = 1'b1; op = CALL;
    #1;
    checks++; if (push !== 1'b0) begin $display("FAIL midreset_push: got %b expected 0", push); errors++; end
    tick();
    reset = 1'b0; op = SEQ;
    checks++; if (pc !== 11'h000 || flush !== 1'b1 || stk_depth !== 5'd0) begin $display("FAIL midreset_state: got pc=%h flush=%b depth=%0d expected 000/1/0", pc, flush, stk_depth); errors++; end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; op = SEQ; target = '0; bra_off = '0;
    skip_cond = 1'b0; ret_addr = '0; stk_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_bra_wrap();
    test_skip_stall();
    test_reset_mid_call();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the PIC16F1826-style core. It is the initiator side of the 16-entry hardware return stack.
- Decodes flow-control ops from the instruction decoder and drives the stack's push/pop/stack_in. It consumes the stack's top-of-stack output on returns.
- Owns the fetch PC, tracks stack depth, raises STKOVF/STKUNF, and generates the one-cycle pipeline flush after every taken change of flow.

Parameters:
- PC_W, 11, program counter / return address width
- DEPTH, 16, return stack entries; must match the stack instance
- RESET_VEC, 0, PC value loaded on reset and on stack underflow

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- en  input  1  pipeline advance; 0 = hold all state
- op  input  3  0 SEQ, 1 GOTO, 2 CALL, 3 RET, 4 BRA, 5 SKIP; 6-7 treated as SEQ
- target  input  PC_W  absolute target for GOTO/CALL
- bra_off  input  9  signed two's-complement offset for BRA
- skip_cond  input  1  SKIP taken when 1
- ret_addr  input  PC_W  top-of-stack value from the stack
- stk_clr  input  1  clears stkovf/stkunf
- pc  output  PC_W  current fetch address (registered)
- push  output  1  stack push strobe (combinational, same cycle as CALL)
- pop  output  1  stack pop strobe (combinational, same cycle as RET)
- stack_in  output  PC_W  return address to push; equals pc
- flush  output  1  1 = instruction presented this cycle is discarded
- stk_depth  output  5  live entries, 0..DEPTH
- stkovf  output  1  sticky overflow flag
- stkunf  output  1  sticky underflow flag

Behaviour:
- Reset values: pc=RESET_VEC, state=FLUSH (so flush=1), stk_depth=0, stkovf=0, stkunf=0. push=pop=0 while reset is asserted.
- States are RUN and FLUSH. flush = (state==FLUSH).
- en=0: pc, state, depth and flags hold; push=pop=0. stk_clr still acts.
- FLUSH with en=1: op is ignored, pc<=pc+1, no push/pop, next state RUN.
- RUN with en=1 (pc is already the address after the executing instruction):
  - SEQ: pc<=pc+1; stay RUN.
  - GOTO: pc<=target; go to FLUSH.
  - CALL: push=1, stack_in=pc, pc<=target, depth+1; go to FLUSH.
  - RET: pop=1, pc<=ret_addr, depth-1; go to FLUSH.
  - BRA: pc<=pc+sext(bra_off); go to FLUSH.
  - SKIP with skip_cond=1: pc<=pc+1; go to FLUSH. With skip_cond=0: behaves as SEQ.
- Arithmetic: all PC sums are modulo 2^PC_W. Wrap from 0x7FF to 0x000 is silent. Negative BRA below 0 wraps.
- Overflow: CALL when stk_depth==DEPTH. push is suppressed (push=0), stkovf<=1, depth stays DEPTH, and the jump to target is still taken.
- Underflow: RET when stk_depth==0. pop is suppressed, stkunf<=1, pc<=RESET_VEC, and the next state is FLUSH.
- Flag priority: stk_clr clears both flags; a same-cycle set wins over stk_clr.
- push and pop are never both 1. push/pop and stack_in are combinational from state, en, op and depth; the stack samples them on the same edge that updates pc.
- Reset mid-operation (including during FLUSH or a CALL cycle) aborts everything: no push/pop is issued that cycle, and all registers take their reset values.

Test Plan:
- Reset then en=1, op=SEQ for 4 cycles -> cycle0 flush=1 with pc=0; then pc reads 1,2,3,4 with flush=0 from cycle1.
- At pc=0x010: CALL target=0x200, then SEQ, then RET with ret_addr=0x010 -> push=1 with stack_in=0x010 and depth 1; pc=0x200 with flush=1; pc=0x201; pop=1; pc=0x010 with flush=1 and depth 0.
- 17 consecutive CALLs (each followed by its flush cycle) -> push=1 on the first 16, depth=16; 17th has push=0 and stkovf=1; stk_clr with no set clears it next cycle.
- RET at depth 0 -> pop=0, stkunf=1, pc=RESET_VEC, flush=1 next cycle.
- pc=0x005, BRA bra_off=0x1F0 (-16) -> pc=0x7F5. pc=0x7FF, SEQ -> pc=0x000.
- SKIP skip_cond=1 at pc=0x020 -> pc=0x021 with flush=1, then 0x022. skip_cond=0 -> pc=0x021 with no flush. en=0 for 3 cycles in between holds pc and flush unchanged.
